// File: rtl/event_blink_driver.sv
// Event-to-blink indicator driver.
// Each accepted single-cycle event produces one lit period of ON_TICKS cycles
// followed by an OFF_TICKS dark gap. Events arriving while a blink is running
// are queued in a saturating pending counter; queued blinks run back-to-back
// with no idle cycle between them.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | no blink running; leaves as soon as pending is non-zero
//   ON    | indicator lit; timer counts 0..ON_TICKS-1
//   OFF   | indicator dark gap; timer counts 0..OFF_TICKS-1, then next or idle
module event_blink_driver #(
    parameter int unsigned N          = 32,
    parameter int unsigned ON_TICKS   = 50000,
    parameter int unsigned OFF_TICKS  = 50000,
    parameter int unsigned CNT_W      = 4,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             event_in,
    input  logic             clear,
    output logic             led_out,
    output logic             busy,
    output logic [CNT_W-1:0] pending,
    output logic             overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } state_t;

    localparam logic [N-1:0]     ON_LAST   = N'(ON_TICKS - 1);
    localparam logic [N-1:0]     OFF_LAST  = N'(OFF_TICKS - 1);
    localparam logic [CNT_W-1:0] PEND_MAX  = '1;
    localparam logic             LED_LIT   = ~ACTIVE_LOW;
    localparam logic             LED_DARK  = ACTIVE_LOW;

    state_t           state;
    state_t           state_nxt;
    logic [N-1:0]     timer;
    logic [N-1:0]     timer_nxt;
    logic [CNT_W-1:0] pending_nxt;
    logic             overflow_nxt;
    logic             start;

    // Next-state and timer logic; 'start' marks the cycle a queued blink begins.
    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        start     = 1'b0;
        case (state)
            IDLE: begin
                if (pending != '0) begin
                    state_nxt = ON;
                    timer_nxt = '0;
                    start     = 1'b1;
                end
            end
            ON: begin
                if (timer == ON_LAST) begin
                    state_nxt = OFF;
                    timer_nxt = '0;
                end else begin
                    timer_nxt = timer + N'(1);
                end
            end
            OFF: begin
                if (timer == OFF_LAST) begin
                    timer_nxt = '0;
                    if (pending != '0) begin
                        state_nxt = ON;
                        start     = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    timer_nxt = timer + N'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                timer_nxt = '0;
            end
        endcase
        if (clear) begin
            state_nxt = IDLE;
            timer_nxt = '0;
            start     = 1'b0;
        end
    end

    // Pending queue: an event and a blink start in the same cycle cancel out,
    // so a full queue still accepts an event on a start cycle.
    always_comb begin
        pending_nxt  = pending;
        overflow_nxt = 1'b0;
        if (clear) begin
            pending_nxt = '0;
        end else if (event_in && !start) begin
            if (pending == PEND_MAX) begin
                overflow_nxt = 1'b1;
            end else begin
                pending_nxt = pending + CNT_W'(1);
            end
        end else if (!event_in && start) begin
            pending_nxt = pending - CNT_W'(1);
        end
    end

    // State, timer, queue and registered outputs (outputs follow next-state).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            timer    <= '0;
            pending  <= '0;
            overflow <= 1'b0;
            busy     <= 1'b0;
            led_out  <= LED_DARK;
        end else begin
            state    <= state_nxt;
            timer    <= timer_nxt;
            pending  <= pending_nxt;
            overflow <= overflow_nxt;
            busy     <= (state_nxt != IDLE);
            led_out  <= (state_nxt == ON) ? LED_LIT : LED_DARK;
        end
    end

endmodule

// File: tb/tb_event_blink_driver.sv
// Bench for event_blink_driver with ON_TICKS=4, OFF_TICKS=3, CNT_W=2, active-low LED.
// A behavioural model (remaining-cycles countdown per blink) predicts each
// cycle's outputs; predictions are queued when stimulus is applied and
// compared when the DUT registers its outputs.
module tb_event_blink_driver;

    localparam int ON   = 4;
    localparam int OFF  = 3;
    localparam int CW   = 2;
    localparam int PMAX = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          event_in;
    logic          clear;
    logic          led_out;
    logic          busy;
    logic [CW-1:0] pending;
    logic          overflow;

    event_blink_driver #(
        .N          (32),
        .ON_TICKS   (ON),
        .OFF_TICKS  (OFF),
        .CNT_W      (CW),
        .ACTIVE_LOW (1'b1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .event_in (event_in),
        .clear    (clear),
        .led_out  (led_out),
        .busy     (busy),
        .pending  (pending),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          led;
        logic          busy;
        logic [CW-1:0] pend;
        logic          ovf;
    } exp_t;

    exp_t sb_q[$];

    int n_checks = 0;
    int n_errors = 0;

    // model state
    int   m_left  = 0;
    int   m_pend  = 0;
    logic m_ovf   = 1'b0;
    int   m_starts = 0;

    // observation statistics
    int   d_starts = 0;
    logic prev_led = 1'b1;
    int   lit_cnt  = 0;
    int   busy_cnt = 0;
    int   ovf_cnt  = 0;
    int   pend_max = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_advance(input logic ev, input logic clr);
        logic st;
        if (clr) begin
            m_left = 0;
            m_pend = 0;
            m_ovf  = 1'b0;
        end else begin
            st    = (m_pend != 0) && (m_left <= 1);
            m_ovf = ev && !st && (m_pend == PMAX);
            if (ev && !st) begin
                if (m_pend < PMAX) m_pend++;
            end else if (!ev && st) begin
                m_pend--;
            end
            if (st) begin
                m_left = ON + OFF;
                m_starts++;
            end else if (m_left > 0) begin
                m_left--;
            end
        end
    endtask

    task automatic clear_stats();
        lit_cnt  = 0;
        busy_cnt = 0;
        ovf_cnt  = 0;
        pend_max = 0;
    endtask

    // One clock cycle: drive, predict, clock, compare.
    task automatic step(input logic ev, input logic clr);
        exp_t e;
        event_in = ev;
        clear    = clr;
        model_advance(ev, clr);
        e.led  = (m_left > OFF) ? 1'b0 : 1'b1;
        e.busy = (m_left != 0);
        e.pend = CW'(m_pend);
        e.ovf  = m_ovf;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        event_in = 1'b0;
        clear    = 1'b0;
        e = sb_q.pop_front();
        check("led_out", 32'(led_out), 32'(e.led));
        check("busy", 32'(busy), 32'(e.busy));
        check("pending", 32'(pending), 32'(e.pend));
        check("overflow", 32'(overflow), 32'(e.ovf));
        if (!led_out && prev_led) d_starts++;
        prev_led = led_out;
        if (!led_out) lit_cnt++;
        if (busy) busy_cnt++;
        if (overflow) ovf_cnt++;
        if (int'(pending) > pend_max) pend_max = int'(pending);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 100; i++) begin
            if (m_left == 0 && m_pend == 0 && busy == 1'b0) break;
            step(1'b0, 1'b0);
        end
        check("drain_idle", 32'(busy), 32'd0);
    endtask

    // Asynchronous reset: outputs must go inactive without a clock edge.
    task automatic apply_reset(input string tag);
        rst_n    = 1'b0;
        event_in = 1'b0;
        clear    = 1'b0;
        #1;
        check({tag, "_led"}, 32'(led_out), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_pend"}, 32'(pending), 32'd0);
        check({tag, "_ovf"}, 32'(overflow), 32'd0);
        m_left   = 0;
        m_pend   = 0;
        m_ovf    = 1'b0;
        prev_led = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n    = 1'b1;
        event_in = 1'b0;
        clear    = 1'b0;
        #2;
        apply_reset("rst0");

        // single event: lit 4 cycles, busy 7 cycles, pending back to 0
        idle(5);
        clear_stats();
        step(1'b1, 1'b0);
        check("s1_pend_t1", 32'(pending), 32'd1);
        idle(12);
        check("s1_lit_cycles", 32'(lit_cnt), 32'd4);
        check("s1_busy_cycles", 32'(busy_cnt), 32'd7);

        // three back-to-back events: continuous busy, pending peaks at 2
        clear_stats();
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        idle(25);
        check("s2_lit_cycles", 32'(lit_cnt), 32'd12);
        check("s2_busy_cycles", 32'(busy_cnt), 32'd21);
        check("s2_pend_peak", 32'(pend_max), 32'd2);

        // event every cycle for 7 cycles: saturation and 3 drops
        clear_stats();
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0);
        drain();
        check("s3_ovf_pulses", 32'(ovf_cnt), 32'd3);
        check("s3_pend_peak", 32'(pend_max), 32'd3);
        check("s3_lit_cycles", 32'(lit_cnt), 32'(4 * ON));

        // full queue and event on a blink-start cycle: no drop
        clear_stats();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        for (int i = 0; i < 40; i++) begin
            if (m_left == 1 && m_pend == PMAX) break;
            step(1'b0, 1'b0);
        end
        check("s4_setup_full", 32'(pending), 32'(PMAX));
        step(1'b1, 1'b0);
        check("s4_pend_held", 32'(pending), 32'(PMAX));
        check("s4_no_ovf", 32'(overflow), 32'd0);
        drain();

        // clear during ON with pending=2, event in the clear cycle ignored
        idle(3);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        check("s5_setup_pend", 32'(pending), 32'd2);
        check("s5_setup_lit", 32'(led_out), 32'd0);
        step(1'b1, 1'b1);
        check("s5_led_dark", 32'(led_out), 32'd1);
        check("s5_busy", 32'(busy), 32'd0);
        check("s5_pend", 32'(pending), 32'd0);
        clear_stats();
        idle(15);
        check("s5_no_blinks", 32'(lit_cnt), 32'd0);

        // reset mid-ON and mid-OFF
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        idle(2);
        apply_reset("rst_on");
        idle(2);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            if (m_left == 2) break;
            step(1'b0, 1'b0);
        end
        apply_reset("rst_off");
        idle(3);
        clear_stats();
        step(1'b1, 1'b0);
        idle(12);
        check("s6_lit_cycles", 32'(lit_cnt), 32'd4);
        check("s6_busy_cycles", 32'(busy_cnt), 32'd7);

        check("blink_count", 32'(d_starts), 32'(m_starts));
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
